rgb_stream_tx: RTL and testbench

RGB_STREAM_TX -- requirements
Module: rgb_stream_tx

---
 rtl/rgb_stream_tx.sv | 156 +++++++++++++++
 tb/tb_rgb_stream_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_stream_tx.sv
// RGB565 -> RGB888 frame streamer. Accepts upstream pixels during ACTIVE and
// frames them with sof/eol, horizontal and vertical blanking, and a done pulse.
module rgb_stream_tx #(
    parameter int H_BLANK = 4,
    parameter int V_BLANK = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] img_width,
    input  logic [11:0] img_height,
    input  logic [15:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        dout_valid,
    output logic [7:0]  r_data,
    output logic [7:0]  g_data,
    output logic [7:0]  b_data,
    output logic        sof,
    output logic        eol,
    output logic        busy,
    output logic        frame_done
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_HBLANK = 2'd2;
    localparam logic [1:0] S_VBLANK = 2'd3;

    localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW   = (BMAX < 2) ? 1 : $clog2(BMAX + 1);
    // Counter runs N-1 down to 0 so a blanking state lasts exactly N cycles.
    localparam logic [BW-1:0] H_LOAD = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [BW-1:0] V_LOAD = BW'((V_BLANK > 0) ? V_BLANK - 1 : 0);

    logic [1:0]    state_q, state_d;
    logic [11:0]   width_q, width_d, height_q, height_d;
    logic [11:0]   pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    logic [BW-1:0] blank_cnt_q, blank_cnt_d;
    logic          dout_valid_q, dout_valid_d, sof_q, sof_d, eol_q, eol_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    r_q, r_d, g_q, g_d, b_q, b_d;
    logic          xfer, last_pix, last_line;

    assign src_ready  = (state_q == S_ACTIVE);
    assign busy       = (state_q != S_IDLE);
    assign dout_valid = dout_valid_q;
    assign r_data     = r_q;
    assign g_data     = g_q;
    assign b_data     = b_q;
    assign sof        = sof_q;
    assign eol        = eol_q;
    assign frame_done = frame_done_q;

    assign xfer      = src_valid && src_ready;
    assign last_pix  = (pix_cnt_q == width_q - 12'd1);
    assign last_line = (line_cnt_q == height_q - 12'd1);

    always_comb begin
        state_d      = state_q;
        width_d      = width_q;
        height_d     = height_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        blank_cnt_d  = blank_cnt_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        dout_valid_d = 1'b0;
        sof_d        = 1'b0;
        eol_d        = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (img_width != 12'd0) && (img_height != 12'd0)) begin
                    width_d    = img_width;
                    height_d   = img_height;
                    pix_cnt_d  = 12'd0;
                    line_cnt_d = 12'd0;
                    state_d    = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (xfer) begin
                    dout_valid_d = 1'b1;
                    r_d   = {src_data[15:11], src_data[15:13]};
                    g_d   = {src_data[10:5],  src_data[10:9]};
                    b_d   = {src_data[4:0],   src_data[4:2]};
                    sof_d = (pix_cnt_q == 12'd0) && (line_cnt_q == 12'd0);
                    eol_d = last_pix;
                    if (last_pix) begin
                        pix_cnt_d  = 12'd0;
                        line_cnt_d = line_cnt_q + 12'd1;
                        if (last_line) begin
                            if (V_BLANK == 0) begin
                                state_d      = S_IDLE;
                                frame_done_d = 1'b1;
                            end else begin
                                state_d     = S_VBLANK;
                                blank_cnt_d = V_LOAD;
                            end
                        end else if (H_BLANK != 0) begin
                            state_d     = S_HBLANK;
                            blank_cnt_d = H_LOAD;
                        end
                    end else begin
                        pix_cnt_d = pix_cnt_q + 12'd1;
                    end
                end
            end
            S_HBLANK: begin
                if (blank_cnt_q == '0) state_d = S_ACTIVE;
                else                   blank_cnt_d = blank_cnt_q - BW'(1);
            end
            default: begin
                if (blank_cnt_q == '0) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    blank_cnt_d = blank_cnt_q - BW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            width_q      <= '0;
            height_q     <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            blank_cnt_q  <= '0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            dout_valid_q <= 1'b0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            width_q      <= width_d;
            height_q     <= height_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            dout_valid_q <= dout_valid_d;
            sof_q        <= sof_d;
            eol_q        <= eol_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_rgb_stream_tx.sv
// Scoreboard bench for rgb_stream_tx: a frame-level model pushes expected
// pixels at each handshake; an independent monitor pops and compares.
module tb_rgb_stream_tx;
    localparam int HB = 4;
    localparam int VB = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] img_width = '0, img_height = '0;
    logic [15:0] src_data = '0;
    logic        src_valid = 1'b0;
    logic        src_ready, dout_valid, sof, eol, busy, frame_done;
    logic [7:0]  r_data, g_data, b_data;

    logic        z_start = 1'b0;
    logic [11:0] z_w = '0, z_h = '0;
    logic [15:0] z_data = '0;
    logic        z_valid = 1'b0;
    logic        z_ready, z_dv, z_sof, z_eol, z_busy, z_fd;
    logic [7:0]  z_r, z_g, z_b;

    always #5 clk = ~clk;

    rgb_stream_tx #(.H_BLANK(HB), .V_BLANK(VB)) u_dut (
        .clk(clk), .rst(rst), .start(start), .img_width(img_width), .img_height(img_height),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .dout_valid(dout_valid), .r_data(r_data), .g_data(g_data), .b_data(b_data),
        .sof(sof), .eol(eol), .busy(busy), .frame_done(frame_done));

    rgb_stream_tx #(.H_BLANK(0), .V_BLANK(0)) u_zero (
        .clk(clk), .rst(rst), .start(z_start), .img_width(z_w), .img_height(z_h),
        .src_data(z_data), .src_valid(z_valid), .src_ready(z_ready),
        .dout_valid(z_dv), .r_data(z_r), .g_data(z_g), .b_data(z_b),
        .sof(z_sof), .eol(z_eol), .busy(z_busy), .frame_done(z_fd));

    typedef struct packed {
        logic [7:0] r, g, b;
        logic       sof, eol;
    } px_t;

    px_t         exp_q[$];
    int          checks = 0, errors = 0;
    int          cyc = 0;
    int          m_w = 1, m_k = 0;
    bit          use_tab = 1'b0;
    logic [15:0] tab_in [5] = '{16'h0000, 16'hFFFF, 16'h07E0, 16'h001F, 16'h8410};
    logic [23:0] tab_exp[5] = '{24'h000000, 24'hFFFFFF, 24'h00FF00, 24'h0000FF, 24'h848284};
    int          out_cnt = 0, sof_cnt = 0, eol_cnt = 0, fd_cnt = 0, stall_cnt = 0;
    int          fd_cyc = 0, last_xfer = 0;
    logic [23:0] hold = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] expand(input logic [15:0] d);
        int r5, g6, b5;
        r5 = int'(d[15:11]);
        g6 = int'(d[10:5]);
        b5 = int'(d[4:0]);
        return {8'((r5 * 8) + (r5 / 4)), 8'((g6 * 4) + (g6 / 16)), 8'((b5 * 8) + (b5 / 4))};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stimulus-side model: the handshake about to be taken at the next edge.
    always @(negedge clk) begin
        if (!rst && src_valid && src_ready) begin
            px_t e;
            e.sof = (m_k == 0);
            e.eol = ((m_k % m_w) == m_w - 1);
            {e.r, e.g, e.b} = (use_tab && m_k < 5) ? tab_exp[m_k] : expand(src_data);
            exp_q.push_back(e);
            m_k++;
            last_xfer = cyc;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold = '0;
        end else begin
            if (busy && !src_ready) stall_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (dout_valid) begin
                out_cnt++;
                if (sof) sof_cnt++;
                if (eol) eol_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(dout_valid), 64'd0);
                end else begin
                    px_t e;
                    e = exp_q.pop_front();
                    chk("pixel", 64'({r_data, g_data, b_data, sof, eol}), 64'(e));
                    hold = {e.r, e.g, e.b};
                end
            end else begin
                chk("bubble_hold", 64'({r_data, g_data, b_data, sof, eol}), 64'({hold, 2'b00}));
            end
        end
    end

    // mode 0: valid held, 1: 1/0 toggle, 2: random valid, 3: sweep table.
    task automatic run_frame(input int w, input int h, input int mode, input logic [15:0] fixd);
        int fd0, st0, o0, s0, e0, i;
        fd0 = fd_cnt; st0 = stall_cnt; o0 = out_cnt; s0 = sof_cnt; e0 = eol_cnt;
        m_w = w; m_k = 0;
        @(posedge clk); #1;
        img_width = 12'(w); img_height = 12'(h); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; img_width = 12'($urandom); img_height = 12'($urandom);
        i = 0;
        while (fd_cnt == fd0 && i < 3000) begin
            case (mode)
                0: src_valid = 1'b1;
                1: src_valid = (i % 2 == 0);
                2: src_valid = 1'($urandom_range(0, 1));
                default: src_valid = 1'b1;
            endcase
            src_data = (mode == 3 && m_k < 5) ? tab_in[m_k] : (mode == 2 ? 16'($urandom) : fixd);
            if (mode == 0 && i == 3) begin
                start = 1'b1; img_width = 12'd7; img_height = 12'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            i++;
        end
        src_valid = 1'b0; start = 1'b0;
        chk("frame_timeout", 64'(fd_cnt == fd0), 64'd0);
        chk("dout_count", 64'(out_cnt - o0), 64'(w * h));
        chk("eol_count", 64'(eol_cnt - e0), 64'(h));
        chk("sof_count", 64'(sof_cnt - s0), 64'd1);
        chk("blank_cycles", 64'(stall_cnt - st0), 64'((h - 1) * HB + VB));
        chk("done_latency", 64'(fd_cyc - last_xfer), 64'(VB + 1));
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after", 64'({busy, src_ready}), 64'd0);
        chk("single_done", 64'(fd_cnt - fd0), 64'd1);
    endtask

    task automatic bad_start(input int w, input int h);
        @(posedge clk); #1;
        img_width = 12'(w); img_height = 12'(h); start = 1'b1; src_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("zero_dim_idle", 64'({busy, src_ready}), 64'd0);
        end
        src_valid = 1'b0;
    endtask

    task automatic z_frame(input int w, input int h);
        int n, zlast, fdc, zst, i;
        logic [15:0] d;
        n = 0; zlast = -1; fdc = -2; zst = 0;
        d = 16'($urandom);
        @(posedge clk); #1;
        z_w = 12'(w); z_h = 12'(h); z_start = 1'b1; z_valid = 1'b1; z_data = d;
        @(posedge clk); #1;
        z_start = 1'b0;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (z_busy && !z_ready) zst++;
            if (z_dv) begin
                chk("z_pixel", 64'({z_r, z_g, z_b, z_sof, z_eol}),
                    64'({expand(d), n == 0, (n % w) == w - 1}));
                n++;
                zlast = cyc;
            end
            if (z_fd) begin
                fdc = cyc;
                break;
            end
        end
        z_valid = 1'b0;
        chk("z_count", 64'(n), 64'(w * h));
        chk("z_done_cycle", 64'(fdc), 64'(zlast));
        chk("z_no_blank", 64'(zst), 64'd0);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("reset_outs", 64'({src_ready, dout_valid, sof, eol, busy, frame_done, r_data, g_data, b_data}), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_frame(4, 2, 0, 16'hF800);
        run_frame(3, 1, 1, 16'h1234);
        use_tab = 1'b1;
        run_frame(5, 1, 3, 16'h0000);
        use_tab = 1'b0;
        bad_start(0, 3);
        bad_start(5, 0);
        for (int k = 0; k < 3; k++)
            run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 4)), 2, 16'h0);
        run_frame(1, 3, 2, 16'h0);
        run_frame(1, 1, 0, 16'hABCD);

        begin : reset_mid_frame
            int o0, fd0, i;
            o0 = out_cnt; fd0 = fd_cnt;
            m_w = 4; m_k = 0;
            @(posedge clk); #1;
            img_width = 12'd4; img_height = 12'd2; start = 1'b1; src_data = 16'hF800;
            @(posedge clk); #1;
            start = 1'b0; src_valid = 1'b1;
            i = 0;
            while (out_cnt < o0 + 5 && i < 100) begin
                @(posedge clk); #1;
                i++;
            end
            chk("pre_reset_timeout", 64'(out_cnt - o0), 64'd5);
            #1 rst = 1'b1;
            #1;
            chk("async_reset_outs", 64'({src_ready, dout_valid, sof, eol, busy, frame_done, r_data, g_data, b_data}), 64'd0);
            src_valid = 1'b0;
            repeat (2) @(posedge clk);
            exp_q.delete();
            #1 rst = 1'b0;
            repeat (6) @(posedge clk);
            #1;
            chk("no_done_after_abort", 64'(fd_cnt - fd0), 64'd0);
            chk("idle_after_abort", 64'(busy), 64'd0);
        end
        run_frame(4, 2, 2, 16'h0);

        z_frame(1, 1);
        z_frame(3, 2);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
